// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans voices one per cycle, then assigns, retriggers or
// releases a voice. When all voices are busy, the oldest gated voice is stolen.
module voice_lane #(
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7,
    parameter int AGE_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr,
    input  logic                  off,
    input  logic                  bump,
    input  logic [NOTE_WIDTH-1:0] note_in,
    input  logic [VEL_WIDTH-1:0]  vel_in,
    output logic [NOTE_WIDTH-1:0] note,
    output logic [VEL_WIDTH-1:0]  vel,
    output logic                  gate,
    output logic                  trig,
    output logic [AGE_WIDTH-1:0]  age
);
    always_ff @(posedge clk) begin
        if (rst) begin
            note <= '0;
            vel  <= '0;
            gate <= 1'b0;
            trig <= 1'b0;
            age  <= '0;
        end else begin
            trig <= 1'b0;
            if (clr) begin
                gate <= 1'b0;
                age  <= '0;
            end else if (wr) begin
                note <= note_in;
                vel  <= vel_in;
                gate <= 1'b1;
                trig <= 1'b1;
                age  <= '0;
            end else begin
                // A release keeps note/vel so the envelope can finish.
                if (off)
                    gate <= 1'b0;
                if (bump && gate && age != '1)
                    age <= age + 1'b1;
            end
        end
    end
endmodule

module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7,
    parameter int AGE_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ev_valid,
    output logic                             ev_ready,
    input  logic                             ev_on,
    input  logic [NOTE_WIDTH-1:0]            ev_note,
    input  logic [VEL_WIDTH-1:0]             ev_vel,
    input  logic                             all_notes_off,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
    output logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_vel,
    output logic [NUM_VOICES-1:0]            note_on,
    output logic [NUM_VOICES-1:0]            voice_trig
);
    localparam int IW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                                 state;
    logic                                   ready_q;
    logic [IW-1:0]                          idx;
    logic                                   l_on;
    logic [NOTE_WIDTH-1:0]                  l_note;
    logic [VEL_WIDTH-1:0]                   l_vel;
    logic                                   found_match, found_free, found_old;
    logic [IW-1:0]                          match_idx, free_idx, old_idx, pick;
    logic [AGE_WIDTH-1:0]                   old_age;
    logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0]  notes;
    logic [NUM_VOICES-1:0][VEL_WIDTH-1:0]   vels;
    logic [NUM_VOICES-1:0][AGE_WIDTH-1:0]   ages;
    logic [NUM_VOICES-1:0]                  gates;
    logic                                   commit;

    // ready_q is the registered handshake; rst only masks it while held.
    assign ev_ready = ready_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            idx         <= '0;
            l_on        <= 1'b0;
            l_note      <= '0;
            l_vel       <= '0;
            found_match <= 1'b0;
            found_free  <= 1'b0;
            found_old   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (all_notes_off) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (ev_valid && ready_q) begin
                        l_on        <= ev_on && (ev_vel != '0);
                        l_note      <= ev_note;
                        l_vel       <= ev_vel;
                        found_match <= 1'b0;
                        found_free  <= 1'b0;
                        found_old   <= 1'b0;
                        idx         <= '0;
                        ready_q     <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (gates[idx] && notes[idx] == l_note && !found_match) begin
                        found_match <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!gates[idx] && !found_free) begin
                        found_free <= 1'b1;
                        free_idx   <= idx;
                    end
                    // Strict '>' keeps the lowest index on equal ages.
                    if (gates[idx] && (!found_old || ages[idx] > old_age)) begin
                        found_old <= 1'b1;
                        old_idx   <= idx;
                        old_age   <= ages[idx];
                    end
                    if (idx == IW'(NUM_VOICES - 1))
                        state <= COMMIT;
                    else
                        idx <= idx + 1'b1;
                end
                COMMIT: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign commit = (state == COMMIT);
    assign pick   = found_match ? match_idx : (found_free ? free_idx : old_idx);

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_lane
        voice_lane #(
            .NOTE_WIDTH(NOTE_WIDTH),
            .VEL_WIDTH (VEL_WIDTH),
            .AGE_WIDTH (AGE_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (all_notes_off),
            .wr     (commit && l_on && pick == IW'(i)),
            .off    (commit && !l_on && found_match && match_idx == IW'(i)),
            .bump   (commit && l_on),
            .note_in(l_note),
            .vel_in (l_vel),
            .note   (notes[i]),
            .vel    (vels[i]),
            .gate   (gates[i]),
            .trig   (voice_trig[i]),
            .age    (ages[i])
        );
    end

    assign voice_note = notes;
    assign voice_vel  = vels;
    assign note_on    = gates;
endmodule

// File: tb/tb_voice_allocator.sv
// Randomized bench for voice_allocator against a timestamp-based allocation model.
module tb_voice_allocator;
    localparam int N  = 8;
    localparam int NW = 7;
    localparam int VW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic          ev_on = 1'b0;
    logic [NW-1:0] ev_note = '0;
    logic [VW-1:0] ev_vel = '0;
    logic          all_notes_off = 1'b0;
    logic [N*NW-1:0] voice_note;
    logic [N*VW-1:0] voice_vel;
    logic [N-1:0]  note_on;
    logic [N-1:0]  voice_trig;

    voice_allocator #(.NUM_VOICES(N), .NOTE_WIDTH(NW), .VEL_WIDTH(VW), .AGE_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
        .ev_note(ev_note), .ev_vel(ev_vel), .all_notes_off(all_notes_off),
        .voice_note(voice_note), .voice_vel(voice_vel), .note_on(note_on), .voice_trig(voice_trig)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model: age of a gated voice = note-on commits since it was assigned, saturated.
    int       m_note [N];
    int       m_vel  [N];
    bit       m_gate [N];
    int       m_stamp[N];
    int       cnt = 0;
    logic [N-1:0] exp_trig = '0;
    bit       exp_rdy = 0;
    logic [N-1:0] trig_seen;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int age_of(input int v);
        return (cnt - m_stamp[v] > 255) ? 255 : cnt - m_stamp[v];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_note[i] = 0; m_vel[i] = 0; m_gate[i] = 0; m_stamp[i] = 0;
        end
        cnt = 0;
        exp_trig = '0;
    endtask

    task automatic model_panic();
        for (int i = 0; i < N; i++) m_gate[i] = 0;
        exp_trig = '0;
        exp_rdy  = 0;
    endtask

    task automatic model_commit(input bit on, input int note, input int vel);
        int v;
        v = -1;
        for (int i = 0; i < N; i++)
            if (v < 0 && m_gate[i] && m_note[i] == note) v = i;
        if (on && vel != 0) begin
            for (int i = 0; i < N; i++)
                if (v < 0 && !m_gate[i]) v = i;
            if (v < 0) begin
                v = 0;
                for (int i = 1; i < N; i++)
                    if (age_of(i) > age_of(v)) v = i;
            end
            cnt++;
            m_note[v] = note; m_vel[v] = vel; m_gate[v] = 1; m_stamp[v] = cnt;
            exp_trig = '0;
            exp_trig[v] = 1'b1;
        end else if (v >= 0) begin
            m_gate[v] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N*NW-1:0] en;
            logic [N*VW-1:0] ev;
            logic [N-1:0]    eg;
            for (int i = 0; i < N; i++) begin
                en[i*NW +: NW] = NW'(m_note[i]);
                ev[i*VW +: VW] = VW'(m_vel[i]);
                eg[i] = m_gate[i];
            end
            cmp("ev_ready",   64'(ev_ready),   64'(exp_rdy));
            cmp("note_on",    64'(note_on),    64'(eg));
            cmp("voice_trig", 64'(voice_trig), 64'(exp_trig));
            cmp("voice_note", 64'(voice_note), 64'(en));
            cmp("voice_vel",  64'(voice_vel),  64'(ev));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pk: edge index (0 = accept edge) on which all_notes_off fires; -1 for none.
    task automatic send(input bit on, input int note, input int vel, input int pk);
        ev_valid = 1; ev_on = on; ev_note = NW'(note); ev_vel = VW'(vel);
        if (pk == 0) all_notes_off = 1;
        step();
        ev_valid = 0;
        if (pk == 0) begin
            model_panic(); all_notes_off = 0; step(); exp_rdy = 1; return;
        end
        exp_rdy = 0;
        for (int e = 1; e <= N + 1; e++) begin
            if (e == pk) all_notes_off = 1;
            step();
            if (e == pk) begin
                model_panic(); all_notes_off = 0; step(); exp_rdy = 1; return;
            end
            if (e == N + 1) begin
                model_commit(on, note, vel);
                exp_rdy = 1;
                trig_seen = voice_trig;
            end
        end
        step();
        exp_trig = '0;
    endtask

    task automatic panic();
        all_notes_off = 1;
        step();
        model_panic();
        all_notes_off = 0;
        step();
        exp_rdy = 1;
    endtask

    initial begin
        model_reset();
        exp_rdy = 0;
        step(); step();
        chk_en = 1;
        step();
        rst = 0; exp_rdy = 1;
        step();

        // Single note-on lands on voice 0.
        send(1, 60, 100, -1);
        cmp("t1_note0", 64'(voice_note[6:0]), 64'd60);
        cmp("t1_vel0",  64'(voice_vel[6:0]),  64'd100);
        cmp("t1_gate",  64'(note_on),         64'h01);
        cmp("t1_trig",  64'(trig_seen),       64'h01);

        // Fill all voices, then steal the oldest.
        panic();
        for (int n = 60; n < 68; n++) send(1, n, 100, -1);
        send(1, 72, 90, -1);
        cmp("t2_gate",  64'(note_on),         64'hFF);
        cmp("t2_trig",  64'(trig_seen),       64'h01);
        cmp("t2_note0", 64'(voice_note[6:0]), 64'd72);

        // Repeated note retriggers the same voice.
        panic();
        send(1, 60, 100, -1);
        send(1, 60, 50, -1);
        cmp("t3_trig", 64'(trig_seen),      64'h01);
        cmp("t3_vel0", 64'(voice_vel[6:0]), 64'd50);
        cmp("t3_gate", 64'(note_on),        64'h01);

        // Release keeps note; freed voice reused first.
        panic();
        send(1, 60, 100, -1);
        send(1, 62, 100, -1);
        send(0, 60, 0, -1);
        cmp("t4_gate_off", 64'(note_on),         64'h02);
        cmp("t4_note_kept", 64'(voice_note[6:0]), 64'd60);
        send(1, 64, 100, -1);
        cmp("t4_gate",  64'(note_on),         64'h03);
        cmp("t4_note0", 64'(voice_note[6:0]), 64'd64);

        // Velocity-0 note-on releases; unmatched note-off does nothing.
        panic();
        send(1, 50, 10, -1);
        send(1, 51, 20, -1);
        send(1, 60, 30, -1);
        send(1, 60, 0, -1);
        cmp("t5_gate",  64'(note_on),           64'h03);
        cmp("t5_note2", 64'(voice_note[20:14]), 64'd60);
        send(0, 61, 0, -1);
        cmp("t5_nomatch", 64'(note_on), 64'h03);

        // Panic during scan drops the event.
        panic();
        for (int n = 60; n < 68; n++) send(1, n, 100, -1);
        send(1, 70, 90, 3);
        cmp("t6_gate",  64'(note_on),         64'h00);
        cmp("t6_note0", 64'(voice_note[6:0]), 64'd60);
        send(1, 40, 80, -1);
        cmp("t6_next",  64'(voice_note[6:0]), 64'd40);
        cmp("t6_gate2", 64'(note_on),         64'h01);

        // Reset in the middle of an event.
        ev_valid = 1; ev_on = 1; ev_note = 7'd33; ev_vel = 7'd44;
        step();
        ev_valid = 0; exp_rdy = 0;
        step(); step(); step();
        rst = 1;
        step();
        model_reset();
        step();
        rst = 0; exp_rdy = 1;
        step();

        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5)
                panic();
            else if (r < 10)
                send(1, 48 + int'($urandom_range(0, 11)), 1 + int'($urandom_range(0, 126)),
                     int'($urandom_range(0, N + 1)));
            else
                send(r < 70, 48 + int'($urandom_range(0, 11)),
                     ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 127)), -1);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
